bsr_chain: RTL

Parametrised boundary-scan register, the second-generation BSR of the JTAG block. It sits between the TAP controller and the device pads and adds bidirectional pad cells with per-pad output-enable control, a two-bit instruction mode (normal, EXTEST, INTEST, CLAMP), a safe-value preset for output pads, and a shift counter for chain-length checks. All cell storage is clocked on TCK.

---
 rtl/bsr_chain.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/bsr_chain.sv
// Boundary-scan register with in, out and bidirectional pad cells, a NORMAL/EXTEST/INTEST/CLAMP
// pad mux and a saturating shift counter. Define BSR_INTEST_EN to build the INTEST core-side path.
module bsr_chain #(
  parameter int                 NUM_IN    = 9,
  parameter int                 NUM_OUT   = 5,
  parameter int                 NUM_BIDIR = 2,
  parameter logic [NUM_OUT-1:0] SAFE_OUT  = '0,
  localparam int                L         = NUM_IN + 3*NUM_BIDIR + NUM_OUT,
  localparam int                CW        = $clog2(L+1)
) (
  input  logic                 TCK,
  input  logic                 TRST,
  input  logic                 TDI,
  output logic                 TDO,
  input  logic                 dr_capture,
  input  logic                 dr_shift,
  input  logic                 dr_update,
  input  logic                 bsr_select,
  input  logic [1:0]           mode,
  input  logic [NUM_IN-1:0]    parallel_in,
  output logic [NUM_IN-1:0]    to_system_logic,
  input  logic [NUM_OUT-1:0]   parallel_system_logic_out,
  output logic [NUM_OUT-1:0]   to_output_pin,
  input  logic [NUM_BIDIR-1:0] bidir_pin_in,
  input  logic [NUM_BIDIR-1:0] bidir_core_out,
  input  logic [NUM_BIDIR-1:0] bidir_core_oe,
  output logic [NUM_BIDIR-1:0] bidir_to_core,
  output logic [NUM_BIDIR-1:0] bidir_pin_out,
  output logic [NUM_BIDIR-1:0] bidir_pin_oe,
  output logic [CW-1:0]        shift_count
);

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,
    MODE_EXTEST = 2'b01,
    MODE_INTEST = 2'b10,
    MODE_CLAMP  = 2'b11
  } mode_e;

  localparam int BB = NUM_IN;                 // first bidirectional cell
  localparam int OB = NUM_IN + 3*NUM_BIDIR;   // first out cell

  logic [L-1:0]         scan_q, scan_d, cap_vec;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_OUT-1:0]   upd_out_q;
  logic [NUM_BIDIR-1:0] upd_bout_q, upd_boe_q;
  logic [NUM_BIDIR-1:0] scan_bout, scan_boe;
  logic                 cap_en, shf_en, upd_en;
  logic                 pad_ext, pad_int;

  assign cap_en = bsr_select & dr_capture;
  assign shf_en = bsr_select & dr_shift;
  assign upd_en = bsr_select & dr_update;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_cap_in
      assign cap_vec[gi] = parallel_in[gi];
    end
    for (gi = 0; gi < NUM_BIDIR; gi++) begin : g_cap_bidir
      assign cap_vec[BB+3*gi]   = bidir_pin_in[gi];
      assign cap_vec[BB+3*gi+1] = bidir_core_out[gi];
      assign cap_vec[BB+3*gi+2] = bidir_core_oe[gi];
      assign scan_bout[gi]      = scan_q[BB+3*gi+1];
      assign scan_boe[gi]       = scan_q[BB+3*gi+2];
    end
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_cap_out
      assign cap_vec[OB+gi] = parallel_system_logic_out[gi];
    end
  endgenerate

  // Capture wins over shift; the counter saturates at all-ones.
  always_comb begin
    scan_d = scan_q;
    cnt_d  = cnt_q;
    if (cap_en) begin
      scan_d = cap_vec;
      cnt_d  = '0;
    end else if (shf_en) begin
      scan_d = {scan_q[L-2:0], TDI};
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge TCK) begin
    if (!TRST) begin
      scan_q <= '0;
      cnt_q  <= '0;
    end else begin
      scan_q <= scan_d;
      cnt_q  <= cnt_d;
    end
  end

  // Update flops latch the pre-edge scan, so a coincident capture/shift is not seen.
  always_ff @(posedge TCK) begin
    if (!TRST) begin
      upd_out_q  <= SAFE_OUT;
      upd_bout_q <= '0;
      upd_boe_q  <= '0;
    end else if (upd_en) begin
      upd_out_q  <= scan_q[OB +: NUM_OUT];
      upd_bout_q <= scan_bout;
      upd_boe_q  <= scan_boe;
    end
  end

  assign pad_ext = (mode == MODE_EXTEST) || (mode == MODE_CLAMP);

`ifdef BSR_INTEST_EN
  logic [NUM_IN-1:0]    upd_in_q;
  logic [NUM_BIDIR-1:0] upd_bpin_q, scan_bpin;

  generate
    for (gi = 0; gi < NUM_BIDIR; gi++) begin : g_bpin
      assign scan_bpin[gi] = scan_q[BB+3*gi];
    end
  endgenerate

  always_ff @(posedge TCK) begin
    if (!TRST) begin
      upd_in_q   <= '0;
      upd_bpin_q <= '0;
    end else if (upd_en) begin
      upd_in_q   <= scan_q[NUM_IN-1:0];
      upd_bpin_q <= scan_bpin;
    end
  end

  assign pad_int         = (mode == MODE_INTEST);
  assign to_system_logic = pad_int ? upd_in_q : parallel_in;
  assign bidir_to_core   = pad_int ? upd_bpin_q : bidir_pin_in;
`else
  assign pad_int         = 1'b0;
  assign to_system_logic = parallel_in;
  assign bidir_to_core   = bidir_pin_in;
`endif

  always_comb begin
    to_output_pin = parallel_system_logic_out;
    bidir_pin_out = bidir_core_out;
    bidir_pin_oe  = bidir_core_oe;
    if (pad_ext) begin
      to_output_pin = upd_out_q;
      bidir_pin_out = upd_bout_q;
      bidir_pin_oe  = upd_boe_q;
    end else if (pad_int) begin
      to_output_pin = SAFE_OUT;
      bidir_pin_out = '0;
      bidir_pin_oe  = '0;
    end
  end

  assign TDO         = scan_q[L-1];
  assign shift_count = cnt_q;

endmodule
